rv_load_store_unit: RTL and testbench
=====================================

// Module: rv_load_store_unit
// PURPOSE
//   RV32I load/store unit with private byte-lane data RAM, driven by the CPU execute stage.
//   Accepts one load/store request over valid/ready and forms the effective address (base+offset).
//   Checks alignment, range and funct3; performs byte/half/word access with sign/zero extension.
//   Returns a response over valid/ready after a parametrised memory latency.
// PARAMETERS
//   DEPTH_WORDS  256  data RAM depth in 32-bit words (power of two, >=4)
//   BASE_ADDR    0    byte address of RAM word 0 (word-aligned)
//   MEM_LATENCY  1    cycles from accept to response, legal 1..4
//   INIT_FILE    ""   $readmemh image for RAM; "" = no preload
// PORTS
//   clk           in   1   clock
//   reset         in   1   reset, asynchronous, active-high
//   req_valid     in   1   request present
//   req_ready     out  1   unit idle, can accept
//   req_is_store  in   1   1=store (opcode 0100011), 0=load (0000011)
//   req_funct3    in   3   RV32I width/sign code
//   req_base      in   32  rs1 value
//   req_offset    in   32  sign-extended immediate
//   req_wdata     in   32  rs2 value (stores)
//   req_rd        in   5   destination register (loads)
//   rsp_valid     out  1   response present
//   rsp_ready     in   1   consumer accepts response
//   rsp_rdata     out  32  extended load data; 0 for stores and errors
//   rsp_rd        out  5   echoed req_rd
//   rsp_is_store  out  1   echoed req_is_store
//   rsp_err       out  1   misaligned / out-of-range / illegal funct3
// BEHAVIOUR
//   Reset (async): state IDLE; rsp_valid/rsp_err/rsp_is_store=0; rsp_rdata=0; rsp_rd=0.
//   RAM contents are never reset. req_ready=0 while reset is high.
//   FSM IDLE -> ACCESS -> RESP -> IDLE. req_ready = (state==IDLE).
//   IDLE: req_valid at the edge accepts the request.
//     - Latch addr = base+offset, mod 2^32 (wrap legal), plus all request fields.
//     - Error: go straight to RESP (rsp_valid the cycle after accept, rdata=0, err=1).
//     - No error: go to ACCESS with cnt = MEM_LATENCY-1.
//   ACCESS: cnt decrements each edge.
//     - At the edge where cnt==0: store writes enabled byte lanes, load samples the RAM word, go to RESP.
//     - Result: rsp_valid rises exactly MEM_LATENCY cycles after the accept edge.
//   RESP: all rsp_* outputs held stable while rsp_valid && !rsp_ready.
//     - Handshake edge -> IDLE, rsp_valid=0. No accept in the same cycle (throughput 1 op per MEM_LATENCY+2 cycles).
//   Legal funct3
//     - Store: SB=000, SH=001, SW=010.
//     - Load: LB=000, LH=001, LW=010, LBU=100, LHU=101.
//     - Anything else -> err.
//   Misaligned: half with addr[0]=1; word with addr[1:0]!=0 -> err, no memory effect.
//   Range: (addr-BASE_ADDR)>>2 must be < DEPTH_WORDS (unsigned compare on 32-bit difference), else err.
//   Store lanes: SB lane=addr[1:0] gets wdata[7:0]; SH lane pair=addr[1] gets wdata[15:0]; SW all four lanes.
//   Load: LB/LH sign-extend the selected lane(s); LBU/LHU zero-extend; LW full word.
//   Request fields are don't-care when req_valid=0 or req_ready=0. Stores never modify unselected lanes.
//   rd==0 is passed through unchanged; x0 suppression is the register file's responsibility.
//   Reset mid-operation: a store still in ACCESS is abandoned (RAM unchanged); a pending response is dropped.
// STRUCTURE
//   rv32i_pkg holds:
//     - opcodes LOAD/STORE and funct3 constants LB..LHU, SB..SW
//     - lsu_state_t {IDLE, ACCESS, RESP}
//     - functions byte_en(funct3, addr[1:0]) and load_extend(funct3, addr[1:0], word)
//   Sub-module lsu_data_ram: synchronous 4-lane byte-enable RAM (DEPTH_WORDS, INIT_FILE).
//     - One port; write and read at the same edge, read-before-write.
//     - Instantiated once; top-level FSM owns address/error/extension logic.
// TESTING
//   1 SW wdata=0x12345678 base=0x10 off=0x4 -> rsp err=0 after MEM_LATENCY; LW 0x14 -> rdata 0x12345678.
//   2 SB wdata=0xAB at 0x15 -> LBU 0x15 = 0x000000AB, LB 0x15 = 0xFFFFFFAB, LW 0x14 = 0x1234AB78.
//   3 SH 0x8001 at 0x16 -> LH 0x16 = 0xFFFF8001, LHU 0x16 = 0x00008001, LW 0x14 = 0x8001AB78.
//   4 Errors: LW 0x13, SH 0x15, LB funct3=011, LW 0x400 (DEPTH 256) -> err=1, rdata=0, rsp 1 cycle after accept, LW 0x14 unchanged; base=0xFFFFFFFC off=8 -> addr 0x4 legal.
//   5 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 throughout; then accept on cycle after handshake.
//   6 Reset asserted during ACCESS of SW 0xDEADBEEF to 0x20 (MEM_LATENCY=3) -> outputs 0 at once, LW 0x20 returns prior value; repeat 1-3 with MEM_LATENCY=1,3,4.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I load/store opcodes, funct3 codes, LSU state type and lane helpers
package rv32i_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'b00 ? 4'b0001 << a : f3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    return f3 == F3_LB  ? {{24{s[7]}}, s[7:0]} :
           f3 == F3_LH  ? {{16{s[15]}}, s[15:0]} :
           f3 == F3_LBU ? {24'b0, s[7:0]} :
           f3 == F3_LHU ? {16'b0, s[15:0]} : w;
  endfunction
endpackage

// File: rtl/lsu_data_ram.sv
// lsu_data_ram: single-port 4-lane byte-enable RAM, registered read-before-write
module lsu_data_ram #(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  always_ff @(posedge clk)
    if (en) begin
      rdata_q <= mem[addr];
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  assign rdata = rdata_q;
endmodule

// File: rtl/rv_load_store_unit.sv
// rv_load_store_unit: RV32I load/store unit with private data RAM and valid/ready request/response
module rv_load_store_unit import rv32i_pkg::*; #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = '0,
  parameter int          MEM_LATENCY = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_is_store,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  lsu_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, lane_q, lane_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d, off, ram_rdata;
  logic [2:0] f3_q, f3_d;
  logic [4:0] rd_q, rd_d;
  logic store_q, store_d, err_q, err_d, valid_q, valid_d;
  logic bad_f3, misal, req_err, fire;
  // offset is relative to RAM word 0; its low bits equal the address low bits since BASE_ADDR is word-aligned
  assign off     = req_base + req_offset - BASE_ADDR;
  assign bad_f3  = req_is_store ? req_funct3 > F3_SW : req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11;
  assign misal   = req_funct3[1:0] == 2'b01 ? off[0] : req_funct3[1:0] == 2'b10 && off[1:0] != 2'b00;
  assign req_err = bad_f3 || misal || off[31:AW+2] != '0;
  assign fire    = state_q == ACCESS && cnt_q == 2'd0;
  // next-state: accept in IDLE, count down in ACCESS, release on handshake in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    store_d = store_q;
    err_d   = err_q;
    valid_d = valid_q;
    if (state_q == IDLE && req_valid) begin
      state_d = req_err ? RESP : ACCESS;
      cnt_d   = 2'(MEM_LATENCY - 1);
      lane_d  = off[1:0];
      idx_d   = off[AW+1:2];
      wdata_d = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
      f3_d    = req_funct3;
      rd_d    = req_rd;
      store_d = req_is_store;
      err_d   = req_err;
      valid_d = req_err;
    end else if (state_q == ACCESS) begin
      cnt_d   = cnt_q - 2'd1;
      state_d = fire ? RESP : ACCESS;
      valid_d = fire;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end
  // state and response registers; async reset abandons any in-flight access
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      store_q <= store_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  lsu_data_ram #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
    .clk   (clk),
    .en    (fire),
    .we    (fire && store_q ? byte_en(f3_q, lane_q) : 4'b0000),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );
  assign req_ready    = state_q == IDLE && !reset;
  assign rsp_valid    = valid_q;
  assign rsp_err      = err_q;
  assign rsp_is_store = store_q;
  assign rsp_rd       = rd_q;
  assign rsp_rdata    = valid_q && !err_q && !store_q ? load_extend(f3_q, lane_q, ram_rdata) : '0;
endmodule

// File: tb/tb_rv_load_store_unit.sv
// tb_rv_load_store_unit: scoreboarded directed test of three LSUs with latencies 1, 3 and 4
module tb_rv_load_store_unit;
  import rv32i_pkg::*;
  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        st;
    logic        err;
    int          due;
  } exp_t;
  logic clk = 0, reset = 0, req_valid = 0, req_is_store = 0, rsp_ready = 1;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_base = '0, req_offset = '0, req_wdata = '0;
  logic [4:0] req_rd = '0;
  logic [2:0] req_ready, rsp_valid, rsp_is_store, rsp_err;
  logic [31:0] rsp_rdata [3];
  logic [4:0] rsp_rd [3];
  int cyc = 0, nvec = 0, nbad = 0;
  exp_t sb [3][$];
  logic [2:0] seen = '0;
  logic [31:0] snap_d [3];
  logic [7:0] snap_f [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rv_load_store_unit #(.MEM_LATENCY(g == 0 ? 1 : g == 1 ? 3 : 4)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready[g]),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_base     (req_base),
      .req_offset   (req_offset),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_rd       (rsp_rd[g]),
      .rsp_is_store (rsp_is_store[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    return k == 0 ? 1 : k == 1 ? 3 : 4;
  endfunction

  // monitor: compare each new response against the head of its DUT's queue
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rsp_valid[k]) seen[k] = 1'b0;
      else if (!seen[k]) begin
        seen[k] = 1'b1;
        nvec++;
        if (sb[k].size() == 0) begin
          nbad++;
          $display("FAIL dut%0d unexpected_rsp got rdata=%h err=%b want no response", k, rsp_rdata[k], rsp_err[k]);
        end else begin
          e = sb[k].pop_front();
          if (rsp_rdata[k] !== e.rdata || rsp_rd[k] !== e.rd || rsp_is_store[k] !== e.st ||
              rsp_err[k] !== e.err || cyc != e.due) begin
            nbad++;
            $display("FAIL dut%0d rsp got rdata=%h rd=%0d st=%b err=%b cyc=%0d want rdata=%h rd=%0d st=%b err=%b cyc=%0d",
                     k, rsp_rdata[k], rsp_rd[k], rsp_is_store[k], rsp_err[k], cyc, e.rdata, e.rd, e.st, e.err, e.due);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 60 && req_ready != 3'b111; n++) @(negedge clk);
    chk("req_ready_wait", {29'b0, req_ready}, 32'h7);
  endtask

  task automatic expect_all(input logic [31:0] rdata, input logic [4:0] rd, input logic st, input logic err, input int extra);
    for (int k = 0; k < 3; k++)
      sb[k].push_back('{rdata, rd, st, err, cyc + 1 + extra + (err ? 0 : lat(k))});
  endtask

  task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] offs,
                         input logic [31:0] wd, input logic [4:0] rd);
    req_is_store = st;
    req_funct3   = f3;
    req_base     = base;
    req_offset   = offs;
    req_wdata    = wd;
    req_rd       = rd;
    req_valid    = 1'b1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] offs,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata, input logic err);
    wait_ready();
    expect_all(rdata, rd, st, err, 0);
    set_req(st, f3, base, offs, wd, rd);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 60 && (sb[0].size() + sb[1].size() + sb[2].size() != 0 || rsp_valid != 3'b000); n++) @(negedge clk);
    chk("drain_pending", sb[0].size() + sb[1].size() + sb[2].size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, {29'b0, req_ready}, 0);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_rdata"}, rsp_rdata[k], 0);
      chk({nm, "_flags"}, {24'b0, rsp_valid[k], rsp_err[k], rsp_is_store[k], rsp_rd[k]}, 0);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {29'b0, req_ready}, 32'h7);
    // word store then load
    issue(1, F3_SW, 32'h10, 32'h4, 32'h12345678, 5'd1, 32'h0, 0);
    issue(0, F3_LW, 32'h10, 32'h4, 32'h0, 5'd5, 32'h12345678, 0);
    // byte store, sign/zero extension
    issue(1, F3_SB, 32'h15, 32'h0, 32'hFFFFFFAB, 5'd3, 32'h0, 0);
    issue(0, F3_LBU, 32'h14, 32'h1, 32'h0, 5'd6, 32'h000000AB, 0);
    issue(0, F3_LB, 32'h15, 32'h0, 32'h0, 5'd0, 32'hFFFFFFAB, 0);
    issue(0, F3_LW, 32'h14, 32'h0, 32'h0, 5'd7, 32'h1234AB78, 0);
    // half store into upper lanes
    issue(1, F3_SH, 32'h16, 32'h0, 32'h12348001, 5'd2, 32'h0, 0);
    issue(0, F3_LH, 32'h16, 32'h0, 32'h0, 5'd8, 32'hFFFF8001, 0);
    issue(0, F3_LHU, 32'h18, 32'hFFFFFFFE, 32'h0, 5'd9, 32'h00008001, 0);
    issue(0, F3_LW, 32'h14, 32'h0, 32'h0, 5'd10, 32'h8001AB78, 0);
    // errors: misaligned, illegal funct3, out of range
    issue(0, F3_LW, 32'h13, 32'h0, 32'h0, 5'd11, 32'h0, 1);
    issue(1, F3_SH, 32'h15, 32'h0, 32'hFFFF, 5'd12, 32'h0, 1);
    issue(0, 3'b011, 32'h14, 32'h0, 32'h0, 5'd13, 32'h0, 1);
    issue(1, 3'b100, 32'h14, 32'h0, 32'h55, 5'd14, 32'h0, 1);
    issue(0, F3_LW, 32'h400, 32'h0, 32'h0, 5'd15, 32'h0, 1);
    issue(1, F3_SW, 32'h3FF, 32'h1, 32'h11111111, 5'd16, 32'h0, 1);
    issue(0, F3_LW, 32'h14, 32'h0, 32'h0, 5'd17, 32'h8001AB78, 0);
    // address wrap and last legal word
    issue(1, F3_SW, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 5'd18, 32'h0, 0);
    issue(0, F3_LW, 32'h4, 32'h0, 32'h0, 5'd19, 32'hCAFEF00D, 0);
    issue(1, F3_SW, 32'h3FC, 32'h0, 32'hA5A5C3C3, 5'd20, 32'h0, 0);
    issue(0, F3_LHU, 32'h3FE, 32'h0, 32'h0, 5'd21, 32'h0000A5A5, 0);
    drain();
    // backpressure: responses held, no accept until after handshake
    rsp_ready = 1'b0;
    issue(0, F3_LW, 32'h14, 32'h0, 32'h0, 5'd22, 32'h8001AB78, 0);
    for (int n = 0; n < 20 && rsp_valid != 3'b111; n++) @(negedge clk);
    chk("bp_all_valid", {29'b0, rsp_valid}, 32'h7);
    for (int k = 0; k < 3; k++) begin
      snap_d[k] = rsp_rdata[k];
      snap_f[k] = {rsp_valid[k], rsp_err[k], rsp_is_store[k], rsp_rd[k]};
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", {29'b0, req_ready}, 0);
      for (int k = 0; k < 3; k++) begin
        chk("bp_rdata_stable", rsp_rdata[k], snap_d[k]);
        chk("bp_flags_stable", {24'b0, rsp_valid[k], rsp_err[k], rsp_is_store[k], rsp_rd[k]}, {24'b0, snap_f[k]});
      end
    end
    rsp_ready = 1'b1;
    expect_all(32'h00000078, 5'd23, 0, 0, 1);
    set_req(0, F3_LBU, 32'h14, 32'h0, 32'h0, 5'd23);
    @(negedge clk);
    chk("bp_ready_after_hs", {29'b0, req_ready, rsp_valid}, {29'b0, 3'b111, 3'b000});
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    // reset during ACCESS abandons the store
    issue(1, F3_SW, 32'h20, 32'h0, 32'h0BADF00D, 5'd24, 32'h0, 0);
    drain();
    wait_ready();
    set_req(1, F3_SW, 32'h20, 32'h0, 32'hDEADBEEF, 5'd25);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(0, F3_LW, 32'h20, 32'h0, 32'h0, 5'd26, 32'h0BADF00D, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
